// File: rtl/ex_pkg.sv
// Shared types and decode helpers for the EX stage and its multiply/divide engine.
package ex_pkg;

  typedef enum logic [4:0] {
    OP_ADD   = 5'd0,  OP_ADDU  = 5'd1,  OP_SUB   = 5'd2,  OP_SUBU  = 5'd3,
    OP_AND   = 5'd4,  OP_OR    = 5'd5,  OP_XOR   = 5'd6,  OP_NOR   = 5'd7,
    OP_SLT   = 5'd8,  OP_SLTU  = 5'd9,  OP_SLL   = 5'd10, OP_SRL   = 5'd11,
    OP_SRA   = 5'd12, OP_LUI   = 5'd13, OP_MULT  = 5'd14, OP_MULTU = 5'd15,
    OP_DIV   = 5'd16, OP_DIVU  = 5'd17, OP_MFHI  = 5'd18, OP_MFLO  = 5'd19,
    OP_MTHI  = 5'd20, OP_MTLO  = 5'd21
  } ex_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_FIX  = 2'd2
  } md_state_e;

  function automatic logic is_muldiv(input ex_op_e op);
    case (op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: is_muldiv = 1'b1;
      default:                            is_muldiv = 1'b0;
    endcase
  endfunction

  function automatic logic uses_hilo(input ex_op_e op);
    case (op)
      OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO: uses_hilo = 1'b1;
      default:                            uses_hilo = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ex_muldiv.sv
// Iterative multiply/divide engine: one bit per cycle on magnitudes, sign fix-up in FIX.
module ex_muldiv
  import ex_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  ex_op_e          op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  localparam int CW = $clog2(XLEN);

  md_state_e         state_r;
  logic [CW-1:0]     cnt_r;
  logic              is_div_r, neg_q_r, neg_r_r, dz_r;
  logic [XLEN-1:0]   a_r, bm_r, q_r;
  logic [XLEN:0]     acc_r;

  logic              sgn_s;
  logic [XLEN-1:0]   am_s, bm_s, q_nx_s;
  logic [XLEN:0]     acc_nx_s, sum_s, rem_sh_s, diff_s;
  logic [2*XLEN-1:0] prod_s;

  // Operand magnitudes captured at accept time
  always_comb begin
    sgn_s = (op == OP_MULT) || (op == OP_DIV);
    am_s  = (sgn_s && a[XLEN-1]) ? (~a + {{(XLEN-1){1'b0}}, 1'b1}) : a;
    bm_s  = (sgn_s && b[XLEN-1]) ? (~b + {{(XLEN-1){1'b0}}, 1'b1}) : b;
  end

  // One iteration: shift-add multiply, or restoring divide with the dividend shifting out of q
  always_comb begin
    sum_s    = {1'b0, acc_r[XLEN-1:0]} + (q_r[0] ? {1'b0, bm_r} : {(XLEN+1){1'b0}});
    rem_sh_s = {acc_r[XLEN-1:0], q_r[XLEN-1]};
    diff_s   = rem_sh_s - {1'b0, bm_r};
    if (!is_div_r) begin
      acc_nx_s = {1'b0, sum_s[XLEN:1]};
      q_nx_s   = {sum_s[0], q_r[XLEN-1:1]};
    end else if (diff_s[XLEN]) begin
      acc_nx_s = rem_sh_s;
      q_nx_s   = {q_r[XLEN-2:0], 1'b0};
    end else begin
      acc_nx_s = diff_s;
      q_nx_s   = {q_r[XLEN-2:0], 1'b1};
    end
  end

  // Sign correction and divide-by-zero override, valid while in FIX
  always_comb begin
    prod_s = {acc_r[XLEN-1:0], q_r};
    if (neg_q_r) begin
      prod_s = ~prod_s + {{(2*XLEN-1){1'b0}}, 1'b1};
    end else begin
      prod_s = prod_s;
    end
    if (!is_div_r) begin
      hi = prod_s[2*XLEN-1:XLEN];
      lo = prod_s[XLEN-1:0];
    end else if (dz_r) begin
      hi = a_r;
      lo = {XLEN{1'b1}};
    end else begin
      hi = neg_r_r ? (~acc_r[XLEN-1:0] + {{(XLEN-1){1'b0}}, 1'b1}) : acc_r[XLEN-1:0];
      lo = neg_q_r ? (~q_r + {{(XLEN-1){1'b0}}, 1'b1}) : q_r;
    end
    busy = (state_r != MD_IDLE);
    done = (state_r == MD_FIX);
  end

  // Engine FSM and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= MD_IDLE;
      cnt_r    <= {CW{1'b0}};
      is_div_r <= 1'b0;
      neg_q_r  <= 1'b0;
      neg_r_r  <= 1'b0;
      dz_r     <= 1'b0;
      a_r      <= {XLEN{1'b0}};
      bm_r     <= {XLEN{1'b0}};
      q_r      <= {XLEN{1'b0}};
      acc_r    <= {(XLEN+1){1'b0}};
    end else begin
      case (state_r)
        MD_IDLE: begin
          if (start) begin
            state_r  <= MD_RUN;
            cnt_r    <= CW'(XLEN-1);
            is_div_r <= (op == OP_DIV) || (op == OP_DIVU);
            neg_q_r  <= sgn_s && (a[XLEN-1] ^ b[XLEN-1]);
            neg_r_r  <= sgn_s && a[XLEN-1];
            dz_r     <= (b == {XLEN{1'b0}});
            a_r      <= a;
            bm_r     <= bm_s;
            q_r      <= am_s;
            acc_r    <= {(XLEN+1){1'b0}};
          end
        end
        MD_RUN: begin
          acc_r <= acc_nx_s;
          q_r   <= q_nx_s;
          cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
          if (cnt_r == {CW{1'b0}}) begin
            state_r <= MD_FIX;
          end
        end
        MD_FIX:  state_r <= MD_IDLE;
        default: state_r <= MD_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ex_stage_md.sv
// EX stage: forwarding, ALU, HI/LO, mul/div engine and EX/MEM register.
// Optional signed-overflow trap on ADD/SUB when EX_OVF_TRAP_EN is defined.
module ex_stage_md
  import ex_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int RBITS = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid_i,
  input  ex_op_e           op_i,
  input  logic [RBITS-1:0] rs_i,
  input  logic [RBITS-1:0] rt_i,
  input  logic [XLEN-1:0]  data_a_i,
  input  logic [XLEN-1:0]  data_b_i,
  input  logic [XLEN-1:0]  imm_i,
  input  logic             use_imm_i,
  input  logic [RBITS-1:0] dst_i,
  input  logic             reg_write_i,
  input  logic [RBITS-1:0] wb_rd_i,
  input  logic             wb_we_i,
  input  logic [XLEN-1:0]  wb_data_i,
  output logic             stall_o,
  output logic             ex_valid_o,
  output logic [XLEN-1:0]  res_o,
  output logic             zero_o,
  output logic [XLEN-1:0]  store_o,
  output logic [RBITS-1:0] dst_o,
  output logic             reg_write_o,
  output logic             ovf_o
);

  localparam int SW = $clog2(XLEN);

  logic [XLEN-1:0] hi_r, lo_r, md_hi_s, md_lo_s;
  logic [XLEN-1:0] fwd_a_s, fwd_b_s, op_b_s, sum_s, dif_s, res_s;
  logic [SW-1:0]   shamt_s;
  logic            md_busy_s, md_done_s, stall_s, issue_s, ovf_s, wr_s;

  // Operand forwarding: EX/MEM beats MEM/WB, register 0 never forwards
  always_comb begin
    if (reg_write_o && (dst_o != {RBITS{1'b0}}) && (dst_o == rs_i)) begin
      fwd_a_s = res_o;
    end else if (wb_we_i && (wb_rd_i != {RBITS{1'b0}}) && (wb_rd_i == rs_i)) begin
      fwd_a_s = wb_data_i;
    end else begin
      fwd_a_s = data_a_i;
    end
    if (reg_write_o && (dst_o != {RBITS{1'b0}}) && (dst_o == rt_i)) begin
      fwd_b_s = res_o;
    end else if (wb_we_i && (wb_rd_i != {RBITS{1'b0}}) && (wb_rd_i == rt_i)) begin
      fwd_b_s = wb_data_i;
    end else begin
      fwd_b_s = data_b_i;
    end
    op_b_s = use_imm_i ? imm_i : fwd_b_s;
  end

  // ALU and overflow detect
  always_comb begin
    sum_s   = fwd_a_s + op_b_s;
    dif_s   = fwd_a_s - op_b_s;
    shamt_s = fwd_a_s[SW-1:0];
    case (op_i)
      OP_ADD, OP_ADDU: res_s = sum_s;
      OP_SUB, OP_SUBU: res_s = dif_s;
      OP_AND:          res_s = fwd_a_s & op_b_s;
      OP_OR:           res_s = fwd_a_s | op_b_s;
      OP_XOR:          res_s = fwd_a_s ^ op_b_s;
      OP_NOR:          res_s = ~(fwd_a_s | op_b_s);
      OP_SLT:          res_s = {{(XLEN-1){1'b0}}, ($signed(fwd_a_s) < $signed(op_b_s))};
      OP_SLTU:         res_s = {{(XLEN-1){1'b0}}, (fwd_a_s < op_b_s)};
      OP_SLL:          res_s = op_b_s << shamt_s;
      OP_SRL:          res_s = op_b_s >> shamt_s;
      OP_SRA:          res_s = $signed(op_b_s) >>> shamt_s;
      OP_LUI:          res_s = imm_i << (XLEN/2);
      OP_MFHI:         res_s = hi_r;
      OP_MFLO:         res_s = lo_r;
      default:         res_s = {XLEN{1'b0}};
    endcase
`ifdef EX_OVF_TRAP_EN
    case (op_i)
      OP_ADD:  ovf_s = (fwd_a_s[XLEN-1] == op_b_s[XLEN-1]) && (sum_s[XLEN-1] != fwd_a_s[XLEN-1]);
      OP_SUB:  ovf_s = (fwd_a_s[XLEN-1] != op_b_s[XLEN-1]) && (dif_s[XLEN-1] != fwd_a_s[XLEN-1]);
      default: ovf_s = 1'b0;
    endcase
`else
    ovf_s = 1'b0;
`endif
    wr_s = reg_write_i && !is_muldiv(op_i) && (op_i != OP_MTHI) && (op_i != OP_MTLO) && !ovf_s;
  end

  // A busy engine holds any HI/LO consumer or a second mul/div in ID/EX
  always_comb begin
    stall_s = id_valid_i && md_busy_s && (is_muldiv(op_i) || uses_hilo(op_i));
    issue_s = id_valid_i && !stall_s;
    stall_o = stall_s;
  end

  ex_muldiv #(.XLEN(XLEN)) u_muldiv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (issue_s && is_muldiv(op_i)),
    .op    (op_i),
    .a     (fwd_a_s),
    .b     (fwd_b_s),
    .busy  (md_busy_s),
    .done  (md_done_s),
    .hi    (md_hi_s),
    .lo    (md_lo_s)
  );

  // HI/LO: engine completion or MTHI/MTLO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_r <= {XLEN{1'b0}};
      lo_r <= {XLEN{1'b0}};
    end else if (md_done_s) begin
      hi_r <= md_hi_s;
      lo_r <= md_lo_s;
    end else if (issue_s && (op_i == OP_MTHI)) begin
      hi_r <= fwd_a_s;
    end else if (issue_s && (op_i == OP_MTLO)) begin
      lo_r <= fwd_a_s;
    end
  end

  // EX/MEM pipeline register; stalls and empty slots load a bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_o  <= 1'b0;
      res_o       <= {XLEN{1'b0}};
      zero_o      <= 1'b0;
      store_o     <= {XLEN{1'b0}};
      dst_o       <= {RBITS{1'b0}};
      reg_write_o <= 1'b0;
      ovf_o       <= 1'b0;
    end else if (!issue_s) begin
      ex_valid_o  <= 1'b0;
      res_o       <= {XLEN{1'b0}};
      zero_o      <= 1'b0;
      store_o     <= {XLEN{1'b0}};
      dst_o       <= {RBITS{1'b0}};
      reg_write_o <= 1'b0;
      ovf_o       <= 1'b0;
    end else begin
      ex_valid_o  <= 1'b1;
      res_o       <= res_s;
      zero_o      <= (res_s == {XLEN{1'b0}});
      store_o     <= fwd_b_s;
      dst_o       <= dst_i;
      reg_write_o <= wr_s;
      ovf_o       <= ovf_s;
    end
  end

endmodule

// File: tb/tb_ex_stage_md.sv
// Directed self-checking bench for ex_stage_md (XLEN=32, RBITS=5).
module tb_ex_stage_md;
  import ex_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid_i;
  ex_op_e      op_i;
  logic [4:0]  rs_i, rt_i, dst_i, wb_rd_i, dst_o;
  logic [31:0] data_a_i, data_b_i, imm_i, wb_data_i, res_o, store_o;
  logic        use_imm_i, reg_write_i, wb_we_i;
  logic        stall_o, ex_valid_o, zero_o, reg_write_o, ovf_o;

  int n_cmp = 0;
  int n_bad = 0;

  ex_stage_md #(.XLEN(32), .RBITS(5)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid_i), .op_i(op_i),
    .rs_i(rs_i), .rt_i(rt_i), .data_a_i(data_a_i), .data_b_i(data_b_i),
    .imm_i(imm_i), .use_imm_i(use_imm_i), .dst_i(dst_i), .reg_write_i(reg_write_i),
    .wb_rd_i(wb_rd_i), .wb_we_i(wb_we_i), .wb_data_i(wb_data_i),
    .stall_o(stall_o), .ex_valid_o(ex_valid_o), .res_o(res_o), .zero_o(zero_o),
    .store_o(store_o), .dst_o(dst_o), .reg_write_o(reg_write_o), .ovf_o(ovf_o)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input ex_op_e op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] dst, input logic rw);
    id_valid_i = 1'b1; op_i = op; rs_i = rs; rt_i = rt; data_a_i = a; data_b_i = b;
    imm_i = 32'd0; use_imm_i = 1'b0; dst_i = dst; reg_write_i = rw;
  endtask

  task automatic idle();
    id_valid_i = 1'b0; reg_write_i = 1'b0; op_i = OP_ADD;
  endtask

  // Reads LO then HI through MFLO/MFHI, waiting (bounded) for the engine
  task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
    int guard;
    drive(OP_MFLO, 5'd0, 5'd0, 32'd0, 32'd0, 5'd9, 1'b1);
    #1;
    guard = 0;
    while (stall_o && guard < 200) begin
      step();
      guard++;
    end
    if (guard >= 200) begin
      n_cmp++; n_bad++;
      $display("FAIL hilo_wait: stall still high after %0d cycles, required release", guard);
    end
    step();
    lo = res_o;
    drive(OP_MFHI, 5'd0, 5'd0, 32'd0, 32'd0, 5'd9, 1'b1);
    step();
    hi = res_o;
    idle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; idle(); rs_i = 5'd0; rt_i = 5'd0; data_a_i = 32'd0; data_b_i = 32'd0;
    imm_i = 32'd0; use_imm_i = 1'b0; dst_i = 5'd0; wb_rd_i = 5'd0; wb_we_i = 1'b0; wb_data_i = 32'd0;
    #2;
    n_cmp++;
    if ({ex_valid_o, res_o, zero_o, store_o, dst_o, reg_write_o, ovf_o, stall_o} !== 74'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h required 0",
               {ex_valid_o, res_o, zero_o, store_o, dst_o, reg_write_o, ovf_o, stall_o});
    end
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_forward();
    wb_we_i = 1'b1; wb_rd_i = 5'd3; wb_data_i = 32'd9;
    drive(OP_ADD, 5'd1, 5'd2, 32'd5, 32'd7, 5'd3, 1'b1);
    step();
    n_cmp++;
    if (res_o !== 32'd12) begin n_bad++; $display("FAIL fwd_first: got %0d required 12", res_o); end
    drive(OP_ADD, 5'd3, 5'd3, 32'd100, 32'd100, 5'd4, 1'b1);
    step();
    n_cmp++;
    if (res_o !== 32'd24 || store_o !== 32'd12) begin
      n_bad++; $display("FAIL fwd_exmem: got res %0d store %0d required 24 12", res_o, store_o);
    end
    drive(OP_ADD, 5'd3, 5'd5, 32'd100, 32'd1, 5'd6, 1'b1);
    step();
    n_cmp++;
    if (res_o !== 32'd10) begin n_bad++; $display("FAIL fwd_memwb: got %0d required 10", res_o); end
    drive(OP_ADD, 5'd1, 5'd1, 32'd1, 32'd1, 5'd0, 1'b1);
    step();
    wb_rd_i = 5'd0;
    drive(OP_ADD, 5'd0, 5'd0, 32'd40, 32'd2, 5'd7, 1'b1);
    step();
    n_cmp++;
    if (res_o !== 32'd42) begin n_bad++; $display("FAIL fwd_r0: got %0d required 42", res_o); end
    wb_we_i = 1'b0;
    idle();
    step();
  endtask

  task automatic test_alu();
    ex_op_e      t_op  [11];
    logic [31:0] t_a   [11];
    logic [31:0] t_b   [11];
    logic [31:0] t_imm [11];
    logic        t_ui  [11];
    logic [31:0] t_exp [11];
    t_op  = '{OP_SUB, OP_SLT, OP_SLTU, OP_SRA, OP_SRL, OP_SLL, OP_LUI, OP_NOR, OP_XOR, OP_AND, OP_OR};
    t_a   = '{32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd4, 32'd4, 32'd4, 32'd0, 32'd0, 32'd5,
              32'h0000F0F0, 32'h0000000F};
    t_b   = '{32'd7, 32'd1, 32'd1, 32'h80000000, 32'h80000000, 32'd1, 32'd0, 32'd0, 32'd5,
              32'h0000FF00, 32'd0};
    t_imm = '{32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'h1234, 32'd0, 32'd0, 32'd0, 32'hF0};
    t_ui  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    t_exp = '{32'hFFFFFFFE, 32'd1, 32'd0, 32'hF8000000, 32'h08000000, 32'd16, 32'h12340000,
              32'hFFFFFFFF, 32'd0, 32'h0000F000, 32'h000000FF};
    for (int i = 0; i < 11; i++) begin
      drive(t_op[i], 5'd1, 5'd2, t_a[i], t_b[i], 5'd7, 1'b1);
      imm_i = t_imm[i]; use_imm_i = t_ui[i];
      step();
      n_cmp++;
      if (res_o !== t_exp[i] || zero_o !== (t_exp[i] == 32'd0) || reg_write_o !== 1'b1) begin
        n_bad++;
        $display("FAIL alu_%0d: got res %h zero %b we %b required %h %b 1",
                 i, res_o, zero_o, reg_write_o, t_exp[i], (t_exp[i] == 32'd0));
      end
    end
    idle();
    step();
  endtask

  task automatic test_mult();
    int cnt;
    drive(OP_MULT, 5'd1, 5'd2, 32'hFFFFFFFD, 32'd7, 5'd0, 1'b0);
    #1;
    n_cmp++;
    if (stall_o !== 1'b0) begin n_bad++; $display("FAIL mult_accept: stall %b required 0", stall_o); end
    step();
    n_cmp++;
    if (reg_write_o !== 1'b0) begin n_bad++; $display("FAIL mult_bubble: we %b required 0", reg_write_o); end
    drive(OP_MFLO, 5'd0, 5'd0, 32'd0, 32'd0, 5'd9, 1'b1);
    #1;
    cnt = 0;
    while (stall_o && cnt < 200) begin
      cnt++;
      step();
    end
    n_cmp++;
    if (cnt !== 33) begin n_bad++; $display("FAIL mult_stall_len: got %0d required 33", cnt); end
    step();
    n_cmp++;
    if (res_o !== 32'hFFFFFFEB) begin n_bad++; $display("FAIL mult_lo: got %h required ffffffeb", res_o); end
    drive(OP_MFHI, 5'd0, 5'd0, 32'd0, 32'd0, 5'd9, 1'b1);
    step();
    n_cmp++;
    if (res_o !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL mult_hi: got %h required ffffffff", res_o); end
    idle();
    step();
  endtask

  task automatic test_div();
    logic [31:0] h, l;
    drive(OP_DIV, 5'd1, 5'd2, 32'hFFFFFFF9, 32'd2, 5'd0, 1'b0);
    step();
    read_hilo(h, l);
    n_cmp++;
    if (l !== 32'hFFFFFFFD || h !== 32'hFFFFFFFF) begin
      n_bad++; $display("FAIL div_signed: got hi %h lo %h required ffffffff fffffffd", h, l);
    end
    drive(OP_DIVU, 5'd1, 5'd2, 32'd7, 32'd0, 5'd0, 1'b0);
    step();
    read_hilo(h, l);
    n_cmp++;
    if (l !== 32'hFFFFFFFF || h !== 32'd7) begin
      n_bad++; $display("FAIL div_zero: got hi %h lo %h required 00000007 ffffffff", h, l);
    end
    drive(OP_DIV, 5'd1, 5'd2, 32'h80000000, 32'hFFFFFFFF, 5'd0, 1'b0);
    step();
    read_hilo(h, l);
    n_cmp++;
    if (l !== 32'h80000000 || h !== 32'd0) begin
      n_bad++; $display("FAIL div_min_neg1: got hi %h lo %h required 00000000 80000000", h, l);
    end
  endtask

  task automatic test_back_to_back();
    int cnt;
    logic [31:0] h, l;
    drive(OP_MULTU, 5'd1, 5'd2, 32'd3, 32'd5, 5'd0, 1'b0);
    step();
    for (int i = 0; i < 10; i++) begin
      drive(OP_ADDU, 5'd1, 5'd2, i, 32'd100, 5'd10, 1'b1);
      #1;
      n_cmp++;
      if (stall_o !== 1'b0) begin n_bad++; $display("FAIL overlap_stall_%0d: stall %b required 0", i, stall_o); end
      step();
      n_cmp++;
      if (res_o !== 32'(i + 100)) begin
        n_bad++; $display("FAIL overlap_res_%0d: got %0d required %0d", i, res_o, i + 100);
      end
    end
    drive(OP_MULTU, 5'd1, 5'd2, 32'd2, 32'd2, 5'd0, 1'b0);
    #1;
    cnt = 0;
    while (stall_o && cnt < 200) begin
      cnt++;
      step();
    end
    n_cmp++;
    if (cnt !== 23) begin n_bad++; $display("FAIL second_mul_stall: got %0d required 23", cnt); end
    step();
    read_hilo(h, l);
    n_cmp++;
    if (l !== 32'd4 || h !== 32'd0) begin
      n_bad++; $display("FAIL second_mul_result: got hi %h lo %h required 0 4", h, l);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] h, l;
    drive(OP_DIV, 5'd1, 5'd2, 32'd100, 32'd3, 5'd0, 1'b0);
    step();
    for (int i = 0; i < 5; i++) begin
      drive(OP_ADDU, 5'd1, 5'd2, i + 1, 32'd1, 5'd10, 1'b1);
      step();
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({ex_valid_o, res_o, zero_o, store_o, dst_o, reg_write_o, ovf_o, stall_o} !== 74'd0) begin
      n_bad++;
      $display("FAIL reset_mid_outputs: got %h required 0",
               {ex_valid_o, res_o, zero_o, store_o, dst_o, reg_write_o, ovf_o, stall_o});
    end
    idle();
    step(); step();
    rst_n = 1'b1;
    drive(OP_MFHI, 5'd0, 5'd0, 32'd0, 32'd0, 5'd9, 1'b1);
    #1;
    n_cmp++;
    if (stall_o !== 1'b0) begin n_bad++; $display("FAIL reset_mid_stall: stall %b required 0", stall_o); end
    read_hilo(h, l);
    n_cmp++;
    if (h !== 32'd0 || l !== 32'd0) begin
      n_bad++; $display("FAIL reset_mid_hilo: got hi %h lo %h required 0 0", h, l);
    end
  endtask

  task automatic test_ovf();
    drive(OP_ADD, 5'd1, 5'd2, 32'h7FFFFFFF, 32'd1, 5'd5, 1'b1);
    step();
    n_cmp++;
`ifdef EX_OVF_TRAP_EN
    if (ovf_o !== 1'b1 || reg_write_o !== 1'b0) begin
      n_bad++; $display("FAIL ovf_add: got ovf %b we %b required 1 0", ovf_o, reg_write_o);
    end
`else
    if (res_o !== 32'h80000000 || ovf_o !== 1'b0 || reg_write_o !== 1'b1) begin
      n_bad++; $display("FAIL ovf_add: got res %h ovf %b we %b required 80000000 0 1", res_o, ovf_o, reg_write_o);
    end
`endif
    drive(OP_ADDU, 5'd1, 5'd2, 32'h7FFFFFFF, 32'd1, 5'd5, 1'b1);
    step();
    n_cmp++;
    if (res_o !== 32'h80000000 || ovf_o !== 1'b0 || reg_write_o !== 1'b1) begin
      n_bad++; $display("FAIL ovf_addu: got res %h ovf %b we %b required 80000000 0 1", res_o, ovf_o, reg_write_o);
    end
    idle();
    step();
  endtask

  initial begin
    test_reset();
    test_forward();
    test_alu();
    test_mult();
    test_div();
    test_back_to_back();
    test_reset_mid();
    test_ovf();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
